mcd_move_ctrl: RTL and testbench

MCD_MOVE_CTRL -- requirements
Module: mcd_move_ctrl

---
 rtl/mcd_move_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mcd_move_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcd_move_ctrl.sv
// ---------------------------------------------------------------------------
// mcd_move_ctrl -- step/direction move controller
//
// Issues a train of one-cycle step pulses (en) with a programmable interval,
// tracks a signed step position and reports completion or abort.
//
// Ports
//   clk       in   single rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   request a move (only looked at in IDLE)
//   dir_cmd   in   direction of the requested move (0 fwd, 1 rev)
//   steps     in   CNT_W  number of steps to issue
//   period    in   CNT_W  cycles between step pulses (0 behaves as 1)
//   abort     in   stop the running move
//   dir       out  registered direction for the step driver
//   en        out  one-cycle step pulse
//   busy      out  move in progress
//   done      out  one-cycle pulse at end of a move
//   aborted   out  qualifies done; held until the next move is accepted
//   position  out  POS_W signed step position (wraps)
//
// Build option
//   MCD_RAMP_EN  when defined, the first four steps and the last four steps
//                use twice the interval (saturating); the rest use period.
// ---------------------------------------------------------------------------
module mcd_move_ctrl #(
    parameter int POS_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir_cmd,
    input  logic [CNT_W-1:0] steps,
    input  logic [CNT_W-1:0] period,
    input  logic             abort,
    output logic             dir,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] position
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_period;     // effective period of the running move
    logic [CNT_W-1:0] r_cnt;        // interval down-counter
    logic [CNT_W-1:0] r_rem;        // steps still to issue
    logic             r_dir;
    logic             r_aborted;
    logic [POS_W-1:0] r_position;

    logic             w_accept;     // start taken in IDLE
    logic             w_accept_move;// start taken with a non-zero step count
    logic             w_en;
    logic             w_abort_hit;
    logic [CNT_W-1:0] w_eff_period;
    logic [CNT_W-1:0] w_first;      // interval loaded on accept
    logic [CNT_W-1:0] w_reload;     // interval loaded after each step

    assign w_eff_period = (period == '0) ? CNT_ONE : period;

`ifdef MCD_RAMP_EN
    localparam logic [CNT_W-1:0] CNT_FOUR = {{(CNT_W-3){1'b0}}, 3'b100};

    logic [CNT_W-1:0] r_step_idx;   // index of the step currently being timed

    // Slow interval at both ends of the move; doubling saturates at all-ones.
    function automatic logic [CNT_W-1:0] f_interval(
        input logic [CNT_W-1:0] p,
        input logic [CNT_W-1:0] idx,
        input logic [CNT_W-1:0] rem
    );
        logic [CNT_W:0] dbl;
        dbl = {p, 1'b0};
        if (idx < CNT_FOUR || rem <= CNT_FOUR) begin
            f_interval = dbl[CNT_W] ? '1 : dbl[CNT_W-1:0];
        end else begin
            f_interval = p;
        end
    endfunction

    assign w_first  = f_interval(w_eff_period, '0, steps);
    assign w_reload = f_interval(r_period, r_step_idx + CNT_ONE, r_rem - CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_idx <= '0;
        end else if (w_accept_move) begin
            r_step_idx <= '0;
        end else if (w_en) begin
            r_step_idx <= r_step_idx + CNT_ONE;
        end
    end
`else
    assign w_first  = w_eff_period;
    assign w_reload = r_period;
`endif

    // Next-state and pulse decode. en depends on abort combinationally so
    // that an abort in the cycle a step is due suppresses that step.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_en         = 1'b0;
        w_abort_hit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (steps == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_abort_hit  = 1'b1;
                    w_state_next = FINISH;
                end else if (r_cnt == CNT_ONE) begin
                    w_en = 1'b1;
                    if (r_rem == CNT_ONE) begin
                        w_state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_accept_move = w_accept && (steps != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_period   <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dir      <= 1'b0;
            r_aborted  <= 1'b0;
            r_position <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_aborted <= 1'b0;
            end else if (w_abort_hit) begin
                r_aborted <= 1'b1;
            end

            if (w_accept_move) begin
                r_dir    <= dir_cmd;
                r_period <= w_eff_period;
                r_rem    <= steps;
                r_cnt    <= w_first;
            end else if (w_en) begin
                r_rem <= r_rem - CNT_ONE;
                r_cnt <= w_reload;
            end else if (r_state == RUN && !w_abort_hit) begin
                r_cnt <= r_cnt - CNT_ONE;
            end

            if (w_en) begin
                r_position <= r_dir ? (r_position - POS_ONE) : (r_position + POS_ONE);
            end
        end
    end

    assign dir      = r_dir;
    assign en       = w_en;
    assign busy     = (r_state == RUN);
    assign done     = (r_state == FINISH);
    assign aborted  = r_aborted;
    assign position = r_position;

endmodule

// File: tb/tb_mcd_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mcd_move_ctrl -- directed, table-driven bench for mcd_move_ctrl.
// Cycle +k is the k-th cycle after the clock edge that accepts start.
// ---------------------------------------------------------------------------
module tb_mcd_move_ctrl;

    localparam int POS_W = 16;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             dir_cmd;
    logic [CNT_W-1:0] steps;
    logic [CNT_W-1:0] period;
    logic             abort;
    logic             dir;
    logic             en;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [POS_W-1:0] position;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_iv[$];          // expected interval of each step of the next move

    mcd_move_ctrl #(.POS_W(POS_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dir_cmd  (dir_cmd),
        .steps    (steps),
        .period   (period),
        .abort    (abort),
        .dir      (dir),
        .en       (en),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .position (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one move and check en/busy/done/dir every cycle against the
    // step times implied by exp_iv (cumulative sums of the intervals).
    task automatic run_move(
        input string            tag,
        input logic             d,
        input logic [CNT_W-1:0] n,
        input logic [CNT_W-1:0] per,
        input int               abort_at,
        input int               again_at,
        input int               en_cnt,
        input int               done_at,
        input logic             exp_ab,
        input logic [POS_W-1:0] exp_pos
    );
        int en_at[$];
        int t;
        int seen_en;
        logic exp_en;
        t = 0;
        for (int i = 0; i < en_cnt; i++) begin
            t += exp_iv[i];
            en_at.push_back(t);
        end
        start   = 1'b1;
        dir_cmd = d;
        steps   = n;
        period  = per;
        tick();
        seen_en = 0;
        for (int k = 1; k <= done_at + 1; k++) begin
            abort = (k == abort_at);
            if (k == again_at) begin
                start   = 1'b1;
                steps   = 16'd7;
                dir_cmd = ~d;
                period  = 16'd1;
            end else begin
                start = 1'b0;
            end
            #1;
            exp_en = 1'b0;
            foreach (en_at[j]) if (en_at[j] == k) exp_en = 1'b1;
            if (en) seen_en++;
            chk({tag, " en"},   {31'd0, en},   {31'd0, exp_en});
            chk({tag, " busy"}, {31'd0, busy}, {31'd0, (k < done_at)});
            chk({tag, " done"}, {31'd0, done}, {31'd0, (k == done_at)});
            if (k < done_at) chk({tag, " dir"}, {31'd0, dir}, {31'd0, d});
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        chk({tag, " position"}, {16'd0, position}, {16'd0, exp_pos});
        chk({tag, " aborted"},  {31'd0, aborted},  {31'd0, exp_ab});
        $display("move %s: dir=%0d steps=%0d period=%0d en_pulses=%0d position=%0h aborted=%0d",
                 tag, d, n, per, seen_en, position, aborted);
    endtask

    typedef struct {
        logic             d;
        logic [CNT_W-1:0] n;
        logic [CNT_W-1:0] per;
        int               abort_at;
        int               p_eff;
        int               en_cnt;
        int               done_at;
        logic             exp_ab;
        logic [POS_W-1:0] exp_pos;
    } vec_t;

    vec_t vt[5];

    initial begin
        int done_seen;

        rst     = 1'b1;
        start   = 1'b0;
        dir_cmd = 1'b0;
        steps   = '0;
        period  = '0;
        abort   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("reset en",       {31'd0, en},       32'd0);
        chk("reset busy",     {31'd0, busy},     32'd0);
        chk("reset done",     {31'd0, done},     32'd0);
        chk("reset aborted",  {31'd0, aborted},  32'd0);
        chk("reset dir",      {31'd0, dir},      32'd0);
        chk("reset position", {16'd0, position}, 32'd0);
        rst = 1'b0;
        tick();

        // Zero-step move: no en, busy never set, one done pulse with aborted=0
        start = 1'b1; steps = 16'd0; period = 16'd5; dir_cmd = 1'b0;
        tick();
        start = 1'b0;
        done_seen = 0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("zero en",   {31'd0, en},   32'd0);
            chk("zero busy", {31'd0, busy}, 32'd0);
            if (done) begin
                done_seen++;
                chk("zero aborted", {31'd0, aborted}, 32'd0);
            end
            tick();
        end
        chk("zero done pulses", done_seen, 32'd1);
        chk("zero position", {16'd0, position}, 32'd0);
        $display("move zero: steps=0 done_pulses=%0d position=%0h", done_seen, position);

`ifndef MCD_RAMP_EN
        // Hand-computed constant-period moves; positions accumulate row to row.
        vt[0] = '{1'b1, 16'd2,  16'd0, 0,  1, 2, 3,  1'b0, 16'hFFFE};
        vt[1] = '{1'b0, 16'd3,  16'd5, 0,  5, 3, 16, 1'b0, 16'h0001};
        vt[2] = '{1'b0, 16'd10, 16'd4, 12, 4, 2, 13, 1'b1, 16'h0003};
        vt[3] = '{1'b1, 16'd4,  16'd2, 0,  2, 4, 9,  1'b0, 16'hFFFF};
        vt[4] = '{1'b0, 16'd1,  16'd1, 0,  1, 1, 2,  1'b0, 16'h0000};
        for (int r = 0; r < 5; r++) begin
            exp_iv.delete();
            for (int s = 0; s < int'(vt[r].n); s++) exp_iv.push_back(vt[r].p_eff);
            run_move($sformatf("row%0d", r), vt[r].d, vt[r].n, vt[r].per, vt[r].abort_at, 0,
                     vt[r].en_cnt, vt[r].done_at, vt[r].exp_ab, vt[r].exp_pos);
        end

        // Abort between pulses, then aborted must hold through IDLE (abort there is a no-op)
        exp_iv = '{3, 3, 3, 3, 3};
        run_move("abort_mid", 1'b0, 16'd5, 16'd3, 4, 0, 1, 5, 1'b1, 16'h0001);
        abort = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("idle abort done",    {31'd0, done},    32'd0);
            chk("idle abort busy",    {31'd0, busy},    32'd0);
            chk("aborted hold",       {31'd0, aborted}, 32'd1);
            tick();
        end
        // start and abort together in IDLE: start wins, aborted clears
        exp_iv = '{2};
        run_move("start_abort", 1'b1, 16'd1, 16'd2, 0, 0, 1, 3, 1'b0, 16'h0000);

        // Second start during RUN is ignored
        exp_iv = '{5, 5, 5};
        run_move("restart_ign", 1'b0, 16'd3, 16'd5, 0, 3, 3, 16, 1'b0, 16'h0003);
`else
        // Ramp: ends slowed to 2*P
        exp_iv = '{6, 6, 6, 6, 3, 3, 6, 6, 6, 6};
        run_move("ramp", 1'b0, 16'd10, 16'd3, 0, 0, 10, 55, 1'b0, 16'h000A);
`endif

        // Asynchronous reset in the middle of a reverse move
        start = 1'b1; steps = 16'd20; period = 16'd2; dir_cmd = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst en",       {31'd0, en},       32'd0);
        chk("midrst busy",     {31'd0, busy},     32'd0);
        chk("midrst done",     {31'd0, done},     32'd0);
        chk("midrst aborted",  {31'd0, aborted},  32'd0);
        chk("midrst dir",      {31'd0, dir},      32'd0);
        chk("midrst position", {16'd0, position}, 32'd0);
        tick();
        #2;
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (en || busy || done) done_seen++;
        end
        chk("post-reset activity", done_seen, 32'd0);
        chk("post-reset position", {16'd0, position}, 32'd0);
        $display("move reset_mid: post-release activity cycles=%0d position=%0h", done_seen, position);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
